mul_shift_add: RTL and testbench
================================

Name: mul_shift_add

Overview:
- Multi-cycle unsigned shift-and-add multiplier for the FactoCore datapath.
- Consumes the shared W-bit carry-lookahead adder and accumulates one partial product per clock.
- Sits between the factorial controller and the adder: the controller issues op_start with operands and waits for op_done; the block reuses the adder every cycle instead of building a combinational array.

Parameters:
- W, 64, operand width in bits; must be a multiple of 4 (adder is built from 4-bit lookahead groups).
- CW, 7, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- op_start  input  1  single-cycle pulse; begins a multiply when in IDLE or DONE.
- op_clear  input  1  abort/clear; returns to IDLE and zeroes result.
- multiplicand  input  W  operand A, sampled only on the accepting op_start edge.
- multiplier  input  W  operand B, sampled only on the accepting op_start edge.
- result  output  2W  product A*B; valid while op_done=1.
- op_done  output  1  high while in DONE.
- busy  output  1  high while in EXEC.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; result=0; op_done=0; busy=0; counter=0; internal A register=0.
  - Reset beats every other input, including mid-EXEC.
- States are IDLE, EXEC and DONE.
  - op_done = (state==DONE). busy = (state==EXEC). Both are registered state decodes; there is no combinational path from inputs.
- Input priority in every state: reset_n=0, then op_clear=1, then op_start=1.
- IDLE:
  - op_clear: remain IDLE, result=0.
  - op_start: A_reg<=multiplicand; result<={W'b0, multiplier}; counter<=0; state<=EXEC.
- EXEC (one iteration per clock):
  - If result[0]=1: {c, sum} = result[2W-1:W] + A_reg + 0, using the adder with ci=0. Otherwise {c, sum} = {1'b0, result[2W-1:W]}.
  - result <= {c, sum, result[W-1:1]}, a logical right shift of the (2W+1)-bit value {c, sum, low}.
  - counter <= counter+1. When counter==W-1 on this edge, state<=DONE.
  - op_start in EXEC is ignored, and operands are not resampled.
  - op_clear in EXEC aborts: state<=IDLE, result<=0, counter<=0.
- DONE:
  - result is held stable and op_done=1.
  - op_start: accepted exactly as in IDLE (new capture, op_done falls next cycle).
  - op_clear: state<=IDLE, result<=0.
- Latency:
  - Call the accepting op_start edge t0. Iterations occur on edges t1..tW.
  - op_done and the final result are visible after edge tW, so the product is ready exactly W clocks after capture.
  - Latency is fixed and independent of operand values. There is no early termination.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out is always folded into the shifted value, so no overflow is lost.
  - The full 2W-bit product is exact for all operands, including (2^W-1)*(2^W-1).
  - The adder's ci is tied to 0.
- Boundary cases:
  - Either operand 0: result=0 at done.
  - op_start and op_clear in the same cycle: clear wins, no capture.
  - op_start held high continuously: in DONE it retriggers each time DONE is reached. Each product is visible for exactly 1 cycle before the new capture.

Decomposition:
- Shared package fsm_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_EXEC=2'b01, ST_DONE=2'b10 (2'b11 is decoded as IDLE);
  - the default W.
- One natural sub-module: cla_w, a W-bit carry-lookahead adder (inputs a, b, ci; outputs s, co). It is composed of W/4 4-bit lookahead groups chained by group carry-out.
  - The multiplier instantiates exactly one cla_w.
- Counter, FSM and shift register stay in mul_shift_add.

Test Plan:
- Reset mid-EXEC: op_start with A=5, B=7, then reset_n=0 at cycle 3 -> next cycle state IDLE, result=0, op_done=0, busy=0.
- Basic product: A=64'd12, B=64'd10, op_start at t0 -> busy=1 for 64 cycles, op_done=1 after edge t64, result=128'd120, held until op_clear.
- Maximum operands: A=B=64'hFFFF_FFFF_FFFF_FFFF -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 (carry path exercised every iteration).
- Zero and identity: A=0, B=64'h1234 -> result=0. A=64'hDEAD_BEEF, B=1 -> result=128'hDEAD_BEEF. Both complete in exactly 64 cycles.
- Abort and priority:
  - op_clear at cycle 20 of EXEC -> IDLE next cycle, result=0, op_done never asserts.
  - op_start+op_clear together in IDLE -> remains IDLE, no capture.
- Restart from DONE: after 3*4=12, pulse op_start with A=9, B=9 -> op_done low next cycle, operand changes during EXEC ignored, result=81 after 64 cycles.

Source files
------------

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encoding and default datapath width for mul_shift_add.
package fsm_pkg;
  localparam int DEF_W = 64;
  localparam int DEF_CW = 7;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/mul_shift_add_if.sv
// mul_shift_add_if: controller-to-multiplier command/result bundle.
interface mul_shift_add_if
  import fsm_pkg::*;
#(
  parameter int W = DEF_W
);
  logic           op_start;
  logic           op_clear;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] result;
  logic           op_done;
  logic           busy;
  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  result, op_done, busy
  );
  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output result, op_done, busy
  );
endinterface

// File: rtl/cla_w.sv
// cla_w: W-bit adder built from 4-bit carry-lookahead groups chained by group carry.
module cla_w #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  for (genvar i = 0; i < W/4; i++) begin : grp
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = a[4*i +: 4] & b[4*i +: 4];
    assign p = a[4*i +: 4] ^ b[4*i +: 4];
    if (i == 0) begin : first
      assign c[0] = ci;
    end else begin : chain
      assign c[0] = grp[i-1].c[4];
    end
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (&p & c[0]);
    assign s[4*i +: 4] = p ^ c[3:0];
  end
  assign co = grp[W/4-1].c[4];
endmodule

// File: rtl/mul_shift_add.sv
// mul_shift_add: W-cycle unsigned shift-and-add multiplier reusing one cla_w per iteration.
module mul_shift_add
  import fsm_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic               clk,
  input  logic               reset_n,
  mul_shift_add_if.slave     bus
);
  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [W-1:0]   a_reg, a_n;
  logic [2*W-1:0] res, res_n;
  logic [W-1:0]   sum;
  logic           co;
  // Adding zero when the low bit is clear lets the single adder cover both cases.
  cla_w #(.W(W)) u_cla (
    .a  (res[2*W-1:W]),
    .b  (res[0] ? a_reg : '0),
    .ci (1'b0),
    .s  (sum),
    .co (co)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_reg;
    res_n   = res;
    if (bus.op_clear) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      res_n   = '0;
    end else if (state == ST_EXEC) begin
      res_n   = {co, sum, res[W-1:1]};
      cnt_n   = cnt + CW'(1);
      state_n = (cnt == CW'(W-1)) ? ST_DONE : ST_EXEC;
    end else if (bus.op_start) begin
      a_n     = bus.multiplicand;
      res_n   = {{W{1'b0}}, bus.multiplier};
      cnt_n   = '0;
      state_n = ST_EXEC;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_reg <= '0;
      res   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_reg <= a_n;
      res   <= res_n;
    end
  end
  assign bus.result  = res;
  assign bus.op_done = (state == ST_DONE);
  assign bus.busy    = (state == ST_EXEC);
endmodule

// File: tb/tb_mul_shift_add.sv
// tb_mul_shift_add: directed vectors with a queue scoreboard checked on each op_done rise.
module tb_mul_shift_add;
  localparam int W = 64;
  logic clk = 0;
  logic reset_n = 0;
  int vectors = 0;
  int miscompares = 0;
  logic done_q = 0;
  logic [2*W-1:0] q[$];
  mul_shift_add_if #(.W(W)) bus ();
  mul_shift_add #(.W(W), .CW(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n && bus.op_done && !done_q) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got result %h, expected no completion", bus.result);
      end else begin
        logic [2*W-1:0] e;
        e = q.pop_front();
        if (bus.result !== e) begin
          miscompares++;
          $display("FAIL product: got %h, expected %h", bus.result, e);
        end
      end
    end
    done_q = bus.op_done;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.op_done && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.op_start     = 1;
    tick();
    bus.op_start     = 0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
  endtask
  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] exp);
    int n;
    q.push_back(exp);
    start(a, b);
    check({name, "_ack"}, {127'b0, bus.busy & ~bus.op_done}, 128'd1);
    tick();
    tick();
    bus.op_start = 1;
    tick();
    bus.op_start = 0;
    tick();
    tick();
    wait_done(n);
    check({name, "_latency"}, 128'(n + 5), 128'd64);
  endtask
  initial begin
    int n;
    bus.op_start = 0;
    bus.op_clear = 0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    tick();
    tick();
    check("reset_result", bus.result, '0);
    check("reset_flags", {126'b0, bus.busy, bus.op_done}, '0);
    reset_n = 1;
    tick();
    start(64'd5, 64'd7);
    tick();
    tick();
    reset_n = 0;
    tick();
    check("midexec_reset_result", bus.result, '0);
    check("midexec_reset_flags", {126'b0, bus.busy, bus.op_done}, '0);
    reset_n = 1;
    tick();
    run("basic", 64'd12, 64'd10, 128'd120);
    repeat (5) tick();
    check("basic_hold", bus.result, 128'd120);
    check("basic_hold_done", {127'b0, bus.op_done}, 128'd1);
    bus.op_clear = 1;
    tick();
    bus.op_clear = 0;
    check("clear_result", bus.result, '0);
    check("clear_done", {127'b0, bus.op_done}, '0);
    run("max", '1, '1, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run("zero", 64'd0, 64'h1234, '0);
    run("ident", 64'hDEAD_BEEF, 64'd1, 128'hDEAD_BEEF);
    bus.op_clear = 1;
    tick();
    bus.op_clear = 0;
    start(64'd3, 64'd5);
    repeat (19) tick();
    bus.op_clear = 1;
    tick();
    bus.op_clear = 0;
    check("abort_busy", {127'b0, bus.busy}, '0);
    check("abort_result", bus.result, '0);
    repeat (80) tick();
    check("abort_no_done", {127'b0, bus.op_done}, '0);
    bus.op_start = 1;
    bus.op_clear = 1;
    bus.multiplicand = 64'd6;
    bus.multiplier = 64'd6;
    tick();
    bus.op_start = 0;
    bus.op_clear = 0;
    check("start_clear_busy", {127'b0, bus.busy}, '0);
    check("start_clear_result", bus.result, '0);
    run("three_four", 64'd3, 64'd4, 128'd12);
    q.push_back(128'd81);
    start(64'd9, 64'd9);
    check("restart_done_falls", {127'b0, bus.op_done}, '0);
    wait_done(n);
    check("restart_latency", 128'(n), 128'd64);
    bus.op_clear = 1;
    tick();
    bus.op_clear = 0;
    q.push_back(128'd6);
    q.push_back(128'd6);
    bus.multiplicand = 64'd2;
    bus.multiplier = 64'd3;
    bus.op_start = 1;
    wait_done(n);
    check("held_first_latency", 128'(n), 128'd65);
    tick();
    check("held_done_pulse", {127'b0, bus.op_done}, '0);
    wait_done(n);
    check("held_retrigger_latency", 128'(n + 1), 128'd65);
    bus.op_start = 0;
    bus.op_clear = 1;
    tick();
    bus.op_clear = 0;
    tick();
    check("scoreboard_drained", 128'(q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
